aes_axil_cmd_master: RTL and testbench
======================================

Name: aes_axil_cmd_master

Overview:
- Synthesizable AXI4-Lite master that turns single-beat register commands into AXI4-Lite write/read transactions.
- Lets on-chip control logic (key-load/mode sequencer) program the AES core's AXI-Lite slave registers without a processor. Examples: write EXPAND_KEY=2 / ENCRYPT=0 / DECRYPT=1 to addr 0.
- Sits between a simple valid/ready command port and the core's s00_axi slave port.
- One transaction outstanding at a time.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width (matches the AES core register map).
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
- C_TIMEOUT, 256, cycles waited in any AXI phase before timeout_err is set (>=2).

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  register address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP captured
- timeout_err  out  1  sticky: some phase exceeded C_TIMEOUT
- timeout_clr  in  1  clears timeout_err
- m00_axi_awaddr/awprot/awvalid  out  ADDR/3/1; m00_axi_awready in 1
- m00_axi_wdata/wstrb/wvalid  out  32/4/1; m00_axi_wready in 1
- m00_axi_bresp in 2; m00_axi_bvalid in 1; m00_axi_bready out 1
- m00_axi_araddr/arprot/arvalid  out  ADDR/3/1; m00_axi_arready in 1
- m00_axi_rdata in 32; m00_axi_rresp in 2; m00_axi_rvalid in 1; m00_axi_rready out 1

Behaviour:
- Reset values (async on aresetn low, any state):
  - All valids, bready and rready = 0.
  - cmd_ready = 0 while in reset, 1 from the first clock after release.
  - rsp_valid = 0; rsp_rdata = 0; rsp_resp = 0; timeout_err = 0.
  - AXI address/data outputs = 0; awprot = arprot = 3'b000 always.
- FSM states: IDLE, WR (AW/W), WR_B, RD_A, RD_R, RSP. All AXI outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr/wdata/wstrb and go to WR (cmd_write=1) or RD_A (cmd_write=0).
  - awvalid+wvalid, or arvalid, rise the next cycle.
- WR:
  - awvalid and wvalid each stay high until their own handshake, in either order or the same cycle.
  - Each valid drops the cycle after its handshake.
  - Once both handshakes are done, go to WR_B.
- WR_B:
  - bready=1.
  - On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
  - bvalid before WR_B is ignored because bready=0.
- RD_A: arvalid held until arready, then go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid, capture rdata/rresp, go to RSP.
- RSP:
  - rsp_valid=1; outputs stable until rsp_ready, then return to IDLE.
  - rsp_valid and cmd_ready are never high together; a new command is accepted at the earliest the cycle after rsp handshake.
- Minimum latency, zero-wait slave:
  - Write: cmd handshake at cycle N; AW/W handshake N+1; bvalid N+2; rsp_valid N+3.
  - Read: cmd handshake at cycle N; AR handshake N+1; rvalid N+2; rsp_valid N+3.
- Timeout:
  - A per-phase counter resets on entering WR, WR_B, RD_A or RD_R and increments each cycle without completion.
  - At count == C_TIMEOUT, set timeout_err.
  - Valids are never withdrawn (AXI compliance); the FSM keeps waiting.
  - timeout_clr clears timeout_err the next cycle. A simultaneous set wins.
- Responses: SLVERR/DECERR are passed through in rsp_resp unchanged; no retry.
- Reset mid-transaction: all outputs return to reset values immediately, the FSM goes to IDLE, and the pending command is lost.

Test Plan:
- Write addr 0, data 2, wstrb F, zero-wait slave -> AW/W high exactly 1 cycle with awaddr=0, wdata=2; rsp_valid 3 cycles after cmd handshake; rsp_resp=0, rsp_rdata=0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 4 cycles; exactly one rsp.
- Read addr 4, slave returns 0xDEADBEEF with 2-cycle rvalid delay -> rsp_rdata=0xDEADBEEF, rsp_resp=0; rready high only in RD_R.
- Slave bresp=2'b10 -> rsp_resp=2'b10. Hold rsp_ready=0 for 5 cycles -> rsp_valid and outputs stable, cmd_ready=0.
- C_TIMEOUT=8, arready held low 20 cycles -> timeout_err rises at cycle 8 of RD_A; arvalid stays high; transaction still completes; timeout_clr clears the flag.
- Assert aresetn=0 while in WR_B -> all valids/readies 0 immediately. After release, back-to-back commands (write 0x0/1, then read 0x0) both complete in order.

Source files
------------

// File: rtl/aes_axil_cmd_master.sv
// aes_axil_cmd_master
// Converts single-beat register commands into AXI4-Lite write/read transactions
// so that on-chip sequencing logic can program the AES core's slave registers
// without a processor. Only one transaction is in flight at a time.
//
// Ports
//   m00_axi_aclk / m00_axi_aresetn      clock, asynchronous active-low reset
//   cmd_*                               command port (valid/ready), write or read
//   rsp_*                               response port (valid/ready), rdata + resp
//   timeout_err / timeout_clr           sticky "phase waited too long" flag + clear
//   m00_axi_aw*/w*/b*/ar*/r*            AXI4-Lite master port, all outputs registered
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for a command
// ST_WR   | awvalid/wvalid outstanding, each drops after its own handshake
// ST_WR_B | bready high, waiting for the write response
// ST_RD_A | arvalid outstanding
// ST_RD_R | rready high, waiting for read data
// ST_RSP  | rsp_valid high, outputs held until rsp_ready
module aes_axil_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 256
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            timeout_err,
    input  logic                            timeout_clr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                      m00_axi_awprot,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    localparam int CW = $clog2(C_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR, ST_WR_B, ST_RD_A, ST_RD_R, ST_RSP
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [CW-1:0]   timeout_cnt;
    logic            cmd_accept;
    logic            in_phase;
    logic            phase_waiting;

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

    // cmd_ready is a register that is 0 during reset, so the first command can
    // only be taken once the first clock after reset release has loaded it.
    assign cmd_accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
    assign in_phase      = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                           (state_q == ST_RD_A) || (state_q == ST_RD_R);
    assign phase_waiting = in_phase && (state_nxt == state_q);

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) state_q <= ST_IDLE;
        else                  state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (cmd_accept) state_nxt = cmd_write ? ST_WR : ST_RD_A;
            // A valid that is already low has completed its handshake.
            ST_WR:   if ((!m00_axi_awvalid || m00_axi_awready) &&
                         (!m00_axi_wvalid  || m00_axi_wready)) state_nxt = ST_WR_B;
            ST_WR_B: if (m00_axi_bvalid)  state_nxt = ST_RSP;
            ST_RD_A: if (m00_axi_arready) state_nxt = ST_RD_R;
            ST_RD_R: if (m00_axi_rvalid)  state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready)       state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b00;
            timeout_err     <= 1'b0;
            timeout_cnt     <= '0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wstrb   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
        end else begin
            cmd_ready      <= (state_nxt == ST_IDLE);
            rsp_valid      <= (state_nxt == ST_RSP);
            m00_axi_bready <= (state_nxt == ST_WR_B);
            m00_axi_rready <= (state_nxt == ST_RD_R);

            if (m00_axi_awvalid && m00_axi_awready) m00_axi_awvalid <= 1'b0;
            if (m00_axi_wvalid  && m00_axi_wready)  m00_axi_wvalid  <= 1'b0;
            if (m00_axi_arvalid && m00_axi_arready) m00_axi_arvalid <= 1'b0;

            if (cmd_accept) begin
                if (cmd_write) begin
                    m00_axi_awaddr  <= cmd_addr;
                    m00_axi_wdata   <= cmd_wdata;
                    m00_axi_wstrb   <= cmd_wstrb;
                    m00_axi_awvalid <= 1'b1;
                    m00_axi_wvalid  <= 1'b1;
                end else begin
                    m00_axi_araddr  <= cmd_addr;
                    m00_axi_arvalid <= 1'b1;
                end
            end

            if ((state_q == ST_WR_B) && m00_axi_bvalid) begin
                rsp_resp  <= m00_axi_bresp;
                rsp_rdata <= '0;
            end
            if ((state_q == ST_RD_R) && m00_axi_rvalid) begin
                rsp_resp  <= m00_axi_rresp;
                rsp_rdata <= m00_axi_rdata;
            end

            // Counts cycles spent in the current state; restarts on every state
            // change and saturates so it cannot wrap back below the threshold.
            if (state_nxt != state_q)               timeout_cnt <= '0;
            else if (timeout_cnt != CW'(C_TIMEOUT)) timeout_cnt <= timeout_cnt + 1'b1;

            // Set has priority over clear.
            if (phase_waiting && (timeout_cnt == CW'(C_TIMEOUT - 1))) timeout_err <= 1'b1;
            else if (timeout_clr)                                    timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_axil_cmd_master.sv
module tb_aes_axil_cmd_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err, timeout_clr;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;

    aes_axil_cmd_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_TIMEOUT(TO)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .timeout_err(timeout_err), .timeout_clr(timeout_clr),
        .m00_axi_awaddr(m_awaddr), .m00_axi_awprot(m_awprot), .m00_axi_awvalid(m_awvalid),
        .m00_axi_awready(m_awready), .m00_axi_wdata(m_wdata), .m00_axi_wstrb(m_wstrb),
        .m00_axi_wvalid(m_wvalid), .m00_axi_wready(m_wready), .m00_axi_bresp(m_bresp),
        .m00_axi_bvalid(m_bvalid), .m00_axi_bready(m_bready), .m00_axi_araddr(m_araddr),
        .m00_axi_arprot(m_arprot), .m00_axi_arvalid(m_arvalid), .m00_axi_arready(m_arready),
        .m00_axi_rdata(m_rdata), .m00_axi_rresp(m_rresp), .m00_axi_rvalid(m_rvalid),
        .m00_axi_rready(m_rready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic failnote(input string nm);
        total++;
        bad++;
        $display("FAIL %s: actual=event required=no-event (t=%0t)", nm, $time);
    endtask

    // ---------------- reference model and scoreboard queues ----------------
    typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } rsp_t;
    typedef struct packed { logic [3:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    rsp_t        exp_q[$];
    wr_t         exp_wr_q[$];
    logic [3:0]  exp_ar_q[$];

    // Slave register map behaviour: 0xF answers SLVERR, 0xE answers DECERR.
    function automatic logic [1:0] resp_of(input logic [3:0] a);
        return (a == 4'hF) ? 2'b10 : (a == 4'hE) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // ---------------- AXI-Lite slave model ----------------
    int max_dly = 0;
    int nd_aw = -1, nd_w = -1, nd_b = -1, nd_ar = -1, nd_r = -1;
    int aw_hs_cyc, w_hs_cyc, ar_hs_cyc;
    logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
    logic [31:0] cap_wdata;

    function automatic int pick(input int nd);
        if (nd >= 0) return nd;
        return int'($urandom_range(0, unsigned'(max_dly)));
    endfunction

    initial begin
        bit aw_act, w_act, ar_act, got_aw, got_w, got_ar, aw_just, w_just, ar_just;
        bit b_pend, r_pend, b_hs, r_hs, wb_phase, rd_phase;
        int aw_dly, w_dly, ar_dly, b_dly, r_dly;
        logic [1:0]  b_resp_v, r_resp_v;
        logic [31:0] r_data_v;
        wr_t ew;
        logic [3:0] ea;
        {aw_act, w_act, ar_act, got_aw, got_w, got_ar, aw_just, w_just, ar_just} = '0;
        {b_pend, r_pend, b_hs, r_hs, wb_phase, rd_phase} = '0;
        {aw_dly, w_dly, ar_dly, b_dly, r_dly} = '0;
        b_resp_v = 2'b00; r_resp_v = 2'b00; r_data_v = '0;
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        for (int i = 0; i < 16; i++) slv_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
                {aw_act, w_act, ar_act, got_aw, got_w, got_ar, aw_just, w_just, ar_just} = '0;
                {b_pend, r_pend, b_hs, r_hs, wb_phase, rd_phase} = '0;
                continue;
            end
            if (b_hs) begin m_bvalid = 0; b_hs = 0; wb_phase = 0; end
            if (r_hs) begin m_rvalid = 0; r_hs = 0; rd_phase = 0; end
            if (aw_just) begin chk("awvalid_drop", m_awvalid, 0); aw_just = 0; end
            if (w_just)  begin chk("wvalid_drop",  m_wvalid,  0); w_just  = 0; end
            if (ar_just) begin chk("arvalid_drop", m_arvalid, 0); ar_just = 0; end
            if (got_aw && got_w) begin
                if (exp_wr_q.size() == 0) failnote("axi_write_unexpected");
                else begin
                    ew = exp_wr_q.pop_front();
                    chk("awaddr", cap_awaddr, ew.addr);
                    chk("wdata", cap_wdata, ew.data);
                    chk("wstrb", cap_wstrb, ew.strb);
                end
                slv_mem[cap_awaddr] = merge(slv_mem[cap_awaddr], cap_wdata, cap_wstrb);
                b_pend = 1; b_dly = pick(nd_b); nd_b = -1; b_resp_v = resp_of(cap_awaddr);
                wb_phase = 1; got_aw = 0; got_w = 0;
            end
            if (got_ar) begin
                if (exp_ar_q.size() == 0) failnote("axi_read_unexpected");
                else begin ea = exp_ar_q.pop_front(); chk("araddr", cap_araddr, ea); end
                r_pend = 1; r_dly = pick(nd_r); nd_r = -1;
                r_data_v = slv_mem[cap_araddr]; r_resp_v = resp_of(cap_araddr);
                rd_phase = 1; got_ar = 0;
            end
            if (m_bready || wb_phase) chk("bready_only_in_wr_b", m_bready, wb_phase);
            if (m_rready || rd_phase) chk("rready_only_in_rd_r", m_rready, rd_phase);
            m_awready = 0;
            if (m_awvalid && !got_aw) begin
                if (!aw_act) begin aw_act = 1; aw_dly = pick(nd_aw); nd_aw = -1; end
                if (aw_dly == 0) begin
                    m_awready = 1; got_aw = 1; aw_just = 1; aw_act = 0;
                    cap_awaddr = m_awaddr; aw_hs_cyc = cyc + 1;
                end else aw_dly--;
            end else if (aw_act) begin failnote("awvalid_withdrawn"); aw_act = 0; end
            m_wready = 0;
            if (m_wvalid && !got_w) begin
                if (!w_act) begin w_act = 1; w_dly = pick(nd_w); nd_w = -1; end
                if (w_dly == 0) begin
                    m_wready = 1; got_w = 1; w_just = 1; w_act = 0;
                    cap_wdata = m_wdata; cap_wstrb = m_wstrb; w_hs_cyc = cyc + 1;
                end else w_dly--;
            end else if (w_act) begin failnote("wvalid_withdrawn"); w_act = 0; end
            m_arready = 0;
            if (m_arvalid && !got_ar) begin
                if (!ar_act) begin ar_act = 1; ar_dly = pick(nd_ar); nd_ar = -1; end
                if (ar_dly == 0) begin
                    m_arready = 1; got_ar = 1; ar_just = 1; ar_act = 0;
                    cap_araddr = m_araddr; ar_hs_cyc = cyc + 1;
                end else ar_dly--;
            end else if (ar_act) begin failnote("arvalid_withdrawn"); ar_act = 0; end
            if (b_pend) begin
                if (b_dly == 0) begin m_bvalid = 1; m_bresp = b_resp_v; b_pend = 0; end
                else b_dly--;
            end
            if (m_bvalid && m_bready) b_hs = 1;
            if (r_pend) begin
                if (r_dly == 0) begin
                    m_rvalid = 1; m_rdata = r_data_v; m_rresp = r_resp_v; r_pend = 0;
                end else r_dly--;
            end
            if (m_rvalid && m_rready) r_hs = 1;
        end
    end

    // ---------------- response monitor ----------------
    bit          rsp_rand = 0;
    int          hold_req = 0;
    int          last_rsp_cyc = 0;
    int          n_rsp = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;

    initial begin
        bit pend, seen;
        int hold_left;
        logic [31:0] prev_rdata;
        logic [1:0]  prev_resp;
        rsp_t e;
        pend = 0; seen = 0; hold_left = 0; prev_rdata = '0; prev_resp = '0;
        rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin pend = 0; seen = 0; rsp_ready = 0; continue; end
            if (rsp_valid) begin
                chk("rsp_valid_vs_cmd_ready", cmd_ready, 0);
                if (pend) begin
                    chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
                    chk("rsp_resp_stable", rsp_resp, prev_resp);
                end
                if (!seen) begin seen = 1; hold_left = hold_req; hold_req = 0; end
                if (hold_left > 0) begin rsp_ready = 0; hold_left--; end
                else rsp_ready = rsp_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (rsp_ready) begin
                    if (exp_q.size() == 0) failnote("rsp_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", rsp_resp, e.resp);
                    end
                    last_rsp_cyc = cyc + 1; last_rdata = rsp_rdata; last_resp = rsp_resp;
                    n_rsp++; pend = 0; seen = 0;
                end else begin
                    pend = 1; prev_rdata = rsp_rdata; prev_resp = rsp_resp;
                end
            end else begin
                if (pend) failnote("rsp_valid_dropped_before_ready");
                pend = 0; seen = 0;
                rsp_ready = rsp_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int cmd_hs_cyc = 0;

    task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        rsp_t e;
        wr_t  w;
        int   n;
        if (wr) begin
            ref_mem[a] = merge(ref_mem[a], d, s);
            e.rdata = '0; e.resp = resp_of(a);
            w.addr = a; w.data = d; w.strb = s;
            exp_wr_q.push_back(w);
        end else begin
            e.rdata = ref_mem[a]; e.resp = resp_of(a);
            exp_ar_q.push_back(a);
        end
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("cmd_accepted", cmd_ready, 1);
        cmd_hs_cyc = cyc + 1;
        @(posedge clk);
        #1;
        cmd_valid = 0;
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        cmd_write = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain_pending_rsp", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t, n0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        timeout_clr = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        chk("rst_rsp_data", {rsp_rdata, rsp_resp, timeout_err}, 0);
        chk("rst_axi_addr_data", {m_awaddr, m_araddr, m_wdata, m_wstrb}, 0);
        chk("prot", {m_awprot, m_arprot}, 0);
        #2 rst_n = 1;
        @(negedge clk);
        chk("cmd_ready_after_release", cmd_ready, 1);

        // zero-wait write: addr 0, data 2
        max_dly = 0; rsp_rand = 0;
        issue(1, 4'h0, 32'h2, 4'hF); t = cmd_hs_cyc;
        drain();
        chk("t1_aw_latency", aw_hs_cyc - t, 1);
        chk("t1_w_latency", w_hs_cyc - t, 1);
        chk("t1_rsp_latency", last_rsp_cyc - t, 3);

        // awready delayed by 3 cycles, wready immediate
        n0 = n_rsp;
        nd_aw = 3;
        issue(1, 4'h1, 32'h1234_5678, 4'b0011); t = cmd_hs_cyc;
        drain();
        chk("t2_aw_latency", aw_hs_cyc - t, 4);
        chk("t2_w_latency", w_hs_cyc - t, 1);
        chk("t2_one_rsp", n_rsp - n0, 1);

        // zero-wait read, then read with rvalid delayed 2 cycles
        issue(0, 4'h0, 32'h0, 4'h0); t = cmd_hs_cyc;
        drain();
        chk("t3_ar_latency", ar_hs_cyc - t, 1);
        chk("t3_rd_rsp_latency", last_rsp_cyc - t, 3);
        issue(1, 4'h4, 32'hDEAD_BEEF, 4'hF);
        nd_r = 2;
        issue(0, 4'h4, 32'h0, 4'h0); t = cmd_hs_cyc;
        drain();
        chk("t3_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("t3_rd_slow_latency", last_rsp_cyc - t, 5);

        // SLVERR pass-through with rsp_ready held low for 5 cycles, then DECERR read
        hold_req = 5;
        issue(1, 4'hF, 32'h55AA_55AA, 4'hF); t = cmd_hs_cyc;
        drain();
        chk("t4_bresp_slverr", last_resp, 2'b10);
        chk("t4_hold_latency", last_rsp_cyc - t, 8);
        issue(0, 4'hE, 32'h0, 4'h0);
        drain();
        chk("t4_rresp_decerr", last_resp, 2'b11);

        // arready held off for 20 cycles: flag rises after TO waited cycles
        nd_ar = 20;
        issue(0, 4'h1, 32'h0, 4'h0);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == TO - 1) chk("to_not_yet", timeout_err, 0);
            if (k >= TO) begin
                chk("to_set", timeout_err, 1);
                chk("to_arvalid_held", m_arvalid, 1);
            end
        end
        drain();
        chk("to_sticky", timeout_err, 1);
        @(negedge clk); timeout_clr = 1;
        @(negedge clk); timeout_clr = 0;
        chk("to_cleared", timeout_err, 0);

        // reset while waiting in WR_B
        nd_b = 6;
        issue(1, 4'h5, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_wr_b", m_bready, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_outputs",
            {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}, 0);
        exp_q.delete(); exp_wr_q.delete(); exp_ar_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("t6_cmd_ready_back", cmd_ready, 1);
        issue(1, 4'h0, 32'h1, 4'hF);
        issue(0, 4'h0, 32'h0, 4'h0);
        drain();
        chk("t6_readback", last_rdata, 32'h1);

        // randomized traffic with random slave delays and rsp_ready backpressure
        max_dly = 5; rsp_rand = 1;
        repeat (80) begin
            issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom));
        end
        drain();
        chk("rand_no_timeout", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
